// File: rtl/dec_pkg.sv
// Shared types and encoding constants for the RV32I decode stage.
package dec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  localparam logic [6:0] OP_OP    = 7'h33;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_LUI   = 7'h37;

  localparam logic [2:0] FN3_ADD_SUB = 3'd0;
  localparam logic [2:0] FN3_SLL     = 3'd1;
  localparam logic [2:0] FN3_SLT     = 3'd2;
  localparam logic [2:0] FN3_SLTU    = 3'd3;
  localparam logic [2:0] FN3_XOR     = 3'd4;
  localparam logic [2:0] FN3_SRL_SRA = 3'd5;
  localparam logic [2:0] FN3_OR      = 3'd6;
  localparam logic [2:0] FN3_AND     = 3'd7;

  localparam logic [6:0] FN7_BASE = 7'h00;
  localparam logic [6:0] FN7_ALT  = 7'h20;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/reg_file_2r1w.sv
// Two asynchronous read ports, one synchronous write port; x0 is hardwired to zero.
module reg_file_2r1w #(
  parameter int NUM_REGS = 32,
  parameter bit RF_RESET = 1'b1,
  localparam int RA_W = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RA_W-1:0] wa,
  input  logic [31:0]     wd,
  input  logic [RA_W-1:0] ra1,
  output logic [31:0]     rd1,
  input  logic [RA_W-1:0] ra2,
  output logic [31:0]     rd2
);

  logic [31:0] regs [NUM_REGS];

  generate
    if (RF_RESET) begin : g_rst
      // Storage with full clear on reset; writes to x0 are dropped.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
          regs[wa] <= wd;
        end
      end
    end else begin : g_nrst
      // Storage without reset; x0 is masked on the read side instead.
      always_ff @(posedge clk) begin
        if (we && wa != '0) regs[wa] <= wd;
      end
    end
  endgenerate

  assign rd1 = (ra1 == '0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/dec_stage_fwd.sv
// RV32I decode stage: pipeline register, operand bypass, load-use interlock and decode.
module dec_stage_fwd import dec_pkg::*; #(
  parameter int NUM_FWD  = 2,
  parameter int NUM_REGS = 32,
  parameter bit RF_RESET = 1'b1,
  localparam int RA_W = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid,
  input  logic [31:0]             if_pc,
  input  logic [31:0]             if_inst,
  output logic                    if_ready,
  input  logic                    flush,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*RA_W-1:0] fwd_rd,
  input  logic [NUM_FWD*32-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic                    wb_we,
  input  logic [RA_W-1:0]         wb_rd,
  input  logic [31:0]             wb_data,
  input  logic                    ex_ready,
  output logic                    ex_valid,
  output logic [31:0]             ex_pc,
  output logic [RA_W-1:0]         ex_rd,
  output logic                    ex_rd_we,
  output logic [31:0]             ex_src1,
  output logic [31:0]             ex_src2,
  output logic [31:0]             ex_imm,
  output logic                    ex_use_imm,
  output logic [3:0]              ex_alu_op,
  output logic [2:0]              ex_lsu_op,
  output logic                    ex_is_load,
  output logic                    ex_is_store,
  output logic                    ex_illegal
);

  logic        d_valid;
  logic [31:0] d_pc, d_inst;
  logic        fire_ex, hazard;

  logic [RA_W-1:0] fwd_rd_a   [NUM_FWD];
  logic [31:0]     fwd_data_a [NUM_FWD];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
      assign fwd_rd_a[gi]   = fwd_rd[gi*RA_W +: RA_W];
      assign fwd_data_a[gi] = fwd_data[gi*32 +: 32];
    end
  endgenerate

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [RA_W-1:0] rs1, rs2;
  logic [31:0]     rf_rd1, rf_rd2;

  assign opcode = d_inst[6:0];
  assign funct3 = d_inst[14:12];
  assign funct7 = d_inst[31:25];
  assign rs1    = d_inst[15 +: RA_W];
  assign rs2    = d_inst[20 +: RA_W];

  reg_file_2r1w #(.NUM_REGS(NUM_REGS), .RF_RESET(RF_RESET)) u_rf (
    .clk(clk), .rst(rst), .we(wb_we), .wa(wb_rd), .wd(wb_data),
    .ra1(rs1), .rd1(rf_rd1), .ra2(rs2), .rd2(rf_rd2)
  );

  // Handshake: fetch may load whenever D is empty or draining this cycle.
  assign fire_ex  = ex_valid & ex_ready;
  assign if_ready = ~d_valid | fire_ex;
  assign ex_valid = d_valid & ~hazard & ~flush;

  // Pipeline register; flush wins over a load, a load wins over a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_pc    <= '0;
      d_inst  <= NOP_INST;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (if_valid && if_ready) begin
      d_valid <= 1'b1;
      d_pc    <= if_pc;
      d_inst  <= if_inst;
    end else if (fire_ex) begin
      d_valid <= 1'b0;
    end
  end

  logic [31:0] src1_val, src2_val;
  logic        src1_pend, src2_pend;

  // Operand bypass: lower fwd index overrides higher, both override write-back and RF.
  always_comb begin
    src1_val  = rf_rd1;
    src2_val  = rf_rd2;
    src1_pend = 1'b0;
    src2_pend = 1'b0;
    if (wb_we && wb_rd == rs1) src1_val = wb_data;
    if (wb_we && wb_rd == rs2) src2_val = wb_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd_a[i] == rs1) begin
        src1_val  = fwd_data_a[i];
        src1_pend = fwd_pending[i];
      end
      if (fwd_valid[i] && fwd_rd_a[i] == rs2) begin
        src2_val  = fwd_data_a[i];
        src2_pend = fwd_pending[i];
      end
    end
    if (rs1 == '0) begin
      src1_val  = 32'd0;
      src1_pend = 1'b0;
    end
    if (rs2 == '0) begin
      src2_val  = 32'd0;
      src2_pend = 1'b0;
    end
  end

  alu_op_t     alu;
  logic [31:0] imm;
  logic        use_imm, is_load, is_store, rd_we_raw, use1, use2, illegal;
  logic [31:0] imm_i, imm_s, imm_u, imm_sh;

  assign imm_i  = {{20{d_inst[31]}}, d_inst[31:20]};
  assign imm_s  = {{20{d_inst[31]}}, d_inst[31:25], d_inst[11:7]};
  assign imm_u  = {d_inst[31:12], 12'b0};
  assign imm_sh = {27'b0, d_inst[24:20]};

  // Opcode decode into ALU/LSU controls, operand usage and legality.
  always_comb begin
    alu       = ALU_ADD;
    imm       = 32'd0;
    use_imm   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    rd_we_raw = 1'b0;
    use1      = 1'b0;
    use2      = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_OP: begin
        use1 = 1'b1; use2 = 1'b1; rd_we_raw = 1'b1;
        case (funct3)
          FN3_ADD_SUB: alu = (funct7 == FN7_ALT) ? ALU_SUB : ALU_ADD;
          FN3_SLL:     alu = ALU_SLL;
          FN3_SLT:     alu = ALU_SLT;
          FN3_SLTU:    alu = ALU_SLTU;
          FN3_XOR:     alu = ALU_XOR;
          FN3_SRL_SRA: alu = (funct7 == FN7_ALT) ? ALU_SRA : ALU_SRL;
          FN3_OR:      alu = ALU_OR;
          default:     alu = ALU_AND;
        endcase
        illegal = !(funct7 == FN7_BASE ||
                    (funct7 == FN7_ALT && (funct3 == FN3_ADD_SUB || funct3 == FN3_SRL_SRA)));
      end
      OP_IMM: begin
        use1 = 1'b1; rd_we_raw = 1'b1; use_imm = 1'b1; imm = imm_i;
        case (funct3)
          FN3_ADD_SUB: alu = ALU_ADD;
          FN3_SLL: begin
            alu = ALU_SLL; imm = imm_sh; illegal = (funct7 != FN7_BASE);
          end
          FN3_SLT:     alu = ALU_SLT;
          FN3_SLTU:    alu = ALU_SLTU;
          FN3_XOR:     alu = ALU_XOR;
          FN3_SRL_SRA: begin
            alu = (funct7 == FN7_ALT) ? ALU_SRA : ALU_SRL;
            imm = imm_sh;
            illegal = !(funct7 == FN7_BASE || funct7 == FN7_ALT);
          end
          FN3_OR:      alu = ALU_OR;
          default:     alu = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        use1 = 1'b1; rd_we_raw = 1'b1; use_imm = 1'b1; imm = imm_i; is_load = 1'b1;
        illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OP_STORE: begin
        use1 = 1'b1; use2 = 1'b1; use_imm = 1'b1; imm = imm_s; is_store = 1'b1;
        illegal = (funct3 >= 3'd3);
      end
      OP_LUI: begin
        rd_we_raw = 1'b1; use_imm = 1'b1; imm = imm_u; alu = ALU_PASSB;
      end
      default: illegal = 1'b1;
    endcase
    // Register fields beyond the implemented file (RV32E) are only illegal where used.
    if (rd_we_raw && ({1'b0, d_inst[11:7]} >= 6'(NUM_REGS))) illegal = 1'b1;
    if (use1 && ({1'b0, d_inst[19:15]} >= 6'(NUM_REGS))) illegal = 1'b1;
    if (use2 && ({1'b0, d_inst[24:20]} >= 6'(NUM_REGS))) illegal = 1'b1;
  end

  assign hazard = d_valid & ((use1 & src1_pend) | (use2 & src2_pend));

  assign ex_pc       = d_pc;
  assign ex_rd       = d_inst[7 +: RA_W];
  assign ex_rd_we    = rd_we_raw & ~illegal & (d_inst[11:7] != 5'd0);
  assign ex_src1     = src1_val;
  assign ex_src2     = src2_val;
  assign ex_imm      = imm;
  assign ex_use_imm  = use_imm;
  assign ex_alu_op   = alu;
  assign ex_lsu_op   = funct3;
  assign ex_is_load  = is_load;
  assign ex_is_store = is_store;
  assign ex_illegal  = illegal;

endmodule

// File: tb/tb_dec_stage_fwd.sv
// Scoreboard bench for dec_stage_fwd: directed instructions, monitor compares fired packets.
module tb_dec_stage_fwd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0, if_inst = '0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic [1:0]  fwd_valid = '0, fwd_pending = '0;
  logic [9:0]  fwd_rd = '0;
  logic [63:0] fwd_data = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        ex_ready = 1'b1;
  logic        ex_valid, ex_rd_we, ex_use_imm, ex_is_load, ex_is_store, ex_illegal;
  logic [31:0] ex_pc, ex_src1, ex_src2, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_lsu_op;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dec_stage_fwd dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .flush(flush), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .fwd_pending(fwd_pending), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_imm(ex_imm), .ex_use_imm(ex_use_imm), .ex_alu_op(ex_alu_op),
    .ex_lsu_op(ex_lsu_op), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] src1, src2, imm;
    logic        use_imm;
    logic [3:0]  alu;
    logic [2:0]  lsu;
    logic        ld, st, ill;
    bit          c_src2, c_imm, c_alu;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic rd_we,
                      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm,
                      input logic use_imm, input logic [3:0] alu, input logic [2:0] lsu,
                      input logic ld, input logic st, input logic ill,
                      input bit c_src2, input bit c_imm, input bit c_alu);
    exp_t e;
    e.pc = pc; e.rd = rd; e.rd_we = rd_we; e.src1 = s1; e.src2 = s2; e.imm = imm;
    e.use_imm = use_imm; e.alu = alu; e.lsu = lsu; e.ld = ld; e.st = st; e.ill = ill;
    e.c_src2 = c_src2; e.c_imm = c_imm; e.c_alu = c_alu;
    q.push_back(e);
  endtask

  // Monitor: every accepted packet is checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ex_valid && ex_ready) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_packet: got pc %h expected no packet", ex_pc);
        end else begin
          e = q.pop_front();
          $display("packet pc=%h rd=%0d alu=%0d src1=%h src2=%h imm=%h ill=%0b",
                   ex_pc, ex_rd, ex_alu_op, ex_src1, ex_src2, ex_imm, ex_illegal);
          chk("pc", ex_pc, e.pc);
          chk("rd", 32'(ex_rd), 32'(e.rd));
          chk("rd_we", 32'(ex_rd_we), 32'(e.rd_we));
          chk("src1", ex_src1, e.src1);
          if (e.c_src2) chk("src2", ex_src2, e.src2);
          if (e.c_imm) chk("imm", ex_imm, e.imm);
          chk("use_imm", 32'(ex_use_imm), 32'(e.use_imm));
          if (e.c_alu) chk("alu_op", 32'(ex_alu_op), 32'(e.alu));
          if (e.ld || e.st) chk("lsu_op", 32'(ex_lsu_op), 32'(e.lsu));
          chk("is_load", 32'(ex_is_load), 32'(e.ld));
          chk("is_store", 32'(ex_is_store), 32'(e.st));
          chk("illegal", 32'(ex_illegal), 32'(e.ill));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and hold it until fetch sees if_ready.
  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    bit acc = 1'b0;
    if_pc = pc; if_inst = inst; if_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = if_ready;
      step();
    end
    if_valid = 1'b0;
    chk("offer_accepted", 32'(acc), 32'd1);
  endtask

  // Wait until the scoreboard has consumed every expectation.
  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ex_valid", 32'(ex_valid), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ex_valid", 32'(ex_valid), 32'd0);
    chk("post_reset_if_ready", 32'(if_ready), 32'd1);
    step();

    // x1 = 5, x2 = 7
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; step();
    wb_rd = 5'd2; wb_data = 32'd7; step();
    wb_we = 1'b0;

    // add x3,x1,x2 from the register file
    push(32'h100, 5'd3, 1, 32'd5, 32'd7, 0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 1);
    offer(32'h100, 32'h002081B3);
    drain();

    // both bypass sources match x1: index 0 wins
    fwd_valid = 2'b11; fwd_rd = {5'd1, 5'd1}; fwd_data = {32'hBB, 32'hAA};
    push(32'h104, 5'd3, 1, 32'hAA, 32'd0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 1);
    offer(32'h104, 32'h000081B3);
    drain();
    // only index 1 valid
    fwd_valid = 2'b10;
    push(32'h108, 5'd3, 1, 32'hBB, 32'd0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 1);
    offer(32'h108, 32'h000081B3);
    drain();

    // load-use interlock on addi x3,x1,1
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd1}; fwd_data = {32'h0, 32'h123}; fwd_pending = 2'b01;
    push(32'h10C, 5'd3, 1, 32'h123, 0, 32'd1, 1, 4'd0, 0, 0, 0, 0, 0, 1, 1);
    offer(32'h10C, 32'h00108193);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hazard_ex_valid", 32'(ex_valid), 32'd0);
      chk("hazard_if_ready", 32'(if_ready), 32'd0);
      step();
    end
    fwd_pending = 2'b00;
    drain();
    fwd_valid = 2'b00;

    // back-pressure: add x4 stalls, sub x5 waits in fetch
    ex_ready = 1'b0;
    push(32'h140, 5'd4, 1, 32'd5, 32'd7, 0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 1);
    offer(32'h140, 32'h00208233);
    push(32'h144, 5'd5, 1, 32'd7, 32'd5, 0, 0, 4'd1, 0, 0, 0, 0, 1, 0, 1);
    if_pc = 32'h144; if_inst = 32'h401102B3; if_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ex_valid", 32'(ex_valid), 32'd1);
      chk("stall_if_ready", 32'(if_ready), 32'd0);
      chk("stall_src1", ex_src1, 32'd5);
      step();
    end
    ex_ready = 1'b1;
    @(negedge clk);
    chk("release_if_ready", 32'(if_ready), 32'd1);
    step();
    if_valid = 1'b0;
    drain();

    // flush squashes the held instruction and the incoming one
    offer(32'h150, 32'h002081B3);
    flush = 1'b1; if_pc = 32'h154; if_inst = 32'h12345437; if_valid = 1'b1;
    @(negedge clk);
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    step();
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    chk("after_flush_ex_valid", 32'(ex_valid), 32'd0);
    chk("after_flush_if_ready", 32'(if_ready), 32'd1);
    repeat (3) step();

    // sra x3,x1,x0 and the malformed funct7 variant
    push(32'h160, 5'd3, 1, 32'd5, 32'd0, 0, 0, 4'd7, 0, 0, 0, 0, 1, 0, 1);
    offer(32'h160, 32'h4000D1B3);
    push(32'h164, 5'd3, 0, 32'd5, 32'd0, 0, 0, 4'd0, 0, 0, 0, 1, 1, 0, 0);
    offer(32'h164, 32'h8000D1B3);
    drain();

    // write to x0 ignored: add x6,x0,x2
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
    push(32'h170, 5'd6, 1, 32'd0, 32'd7, 0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 1);
    offer(32'h170, 32'h00200333);
    drain();
    // write-through: add x7,x1,x2 while x2 <= 0x99
    wb_rd = 5'd2; wb_data = 32'h99;
    push(32'h174, 5'd7, 1, 32'd5, 32'h99, 0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 1);
    offer(32'h174, 32'h002083B3);
    drain();
    wb_we = 1'b0;

    // sw x2,4(x1); lw x9,-4(x1); lui x8,0x12345
    push(32'h180, 5'd4, 0, 32'd5, 32'h99, 32'd4, 1, 4'd0, 3'd2, 0, 1, 0, 1, 1, 1);
    offer(32'h180, 32'h0020A223);
    push(32'h184, 5'd9, 1, 32'd5, 0, 32'hFFFFFFFC, 1, 4'd0, 3'd2, 1, 0, 0, 0, 1, 1);
    offer(32'h184, 32'hFFC0A483);
    push(32'h188, 5'd8, 1, 32'd0, 0, 32'h12345000, 1, 4'd10, 0, 0, 0, 0, 0, 1, 1);
    offer(32'h188, 32'h12345437);
    drain();

    // reset during a stall drops D and clears the register file
    ex_ready = 1'b0;
    offer(32'h190, 32'h002081B3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall_ex_valid", 32'(ex_valid), 32'd0);
    step();
    rst = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    chk("rst_stall_after_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_stall_after_if_ready", 32'(if_ready), 32'd1);
    repeat (2) step();
    push(32'h194, 5'd3, 1, 32'd0, 32'd0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 1);
    offer(32'h194, 32'h002081B3);
    drain();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
